// File: rtl/phy_rx_pkg.sv
// Shared receive-PHY definitions: comma byte, FSM states, default lock depth.
// Used by serial_paralelo_rx and comma_detect.
package phy_rx_pkg;

  localparam logic [7:0] COMMA_BYTE = 8'hBC;
  localparam int ALIGN_COUNT_DEF = 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LOCK   = 2'd1,
    ACTIVE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/comma_detect.sv
// Combinational 8-bit window compare against the comma byte.
// Position agnostic; the caller decides which cycles count.
module comma_detect
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COMMA = COMMA_BYTE
) (
  input  logic [7:0] win,
  output logic       hit
);

  assign hit = (win == COMMA);

endmodule

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver with comma hunt, lock and byte delivery.
// Optional loss-of-sync detection: define SP_RX_LOS_EN.
module serial_paralelo_rx
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COMMA       = COMMA_BYTE,
  parameter int         ALIGN_COUNT = ALIGN_COUNT_DEF,
  parameter int         LOS_BYTES   = 64
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_stb,
  output logic       active
);

  localparam logic [3:0] ALIGN_N = 4'(ALIGN_COUNT);

  rx_state_e  state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_cnt_q, bc_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       stb_q, stb_d;
  logic       active_q, active_d;

  logic [7:0] win;
  logic       hit;
  logic       slot;

  assign win  = {sr_q[6:0], data_in};
  assign slot = (bit_cnt_q == 3'd7);

  comma_detect #(
    .COMMA (COMMA)
  ) u_comma (
    .win (win),
    .hit (hit)
  );

`ifdef SP_RX_LOS_EN
  localparam logic [7:0] LOS_N = 8'(LOS_BYTES);
  logic [7:0] los_cnt_q, los_cnt_d;
`else
  logic unused_los;
  assign unused_los = (LOS_BYTES != 0);
`endif

  // Next-state: hunt any offset, confirm at slots, deliver bytes once active.
  always_comb begin
    state_d   = state_q;
    sr_d      = win;
    bit_cnt_d = bit_cnt_q + 3'd1;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    stb_d     = 1'b0;
    active_d  = active_q;
`ifdef SP_RX_LOS_EN
    los_cnt_d = los_cnt_q;
`endif
    unique case (state_q)
      HUNT: begin
        if (hit) begin
          bit_cnt_d = 3'd0;
          bc_cnt_d  = 4'd1;
          state_d   = LOCK;
        end
      end
      LOCK: begin
        if (slot) begin
          if (hit) begin
            bc_cnt_d = bc_cnt_q + 4'd1;
            if (bc_cnt_q + 4'd1 == ALIGN_N) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
`ifdef SP_RX_LOS_EN
              los_cnt_d = 8'd0;
`endif
            end
          end else begin
            state_d  = HUNT;
            bc_cnt_d = 4'd0;
          end
        end
      end
      ACTIVE: begin
        if (slot) begin
`ifdef SP_RX_LOS_EN
          if (hit) begin
            los_cnt_d = 8'd0;
          end else begin
            los_cnt_d = los_cnt_q + 8'd1;
          end
          if (!hit && (los_cnt_q + 8'd1 == LOS_N)) begin
            state_d  = HUNT;
            bc_cnt_d = 4'd0;
            active_d = 1'b0;
            valid_d  = 1'b0;
          end else begin
            data_d  = win;
            valid_d = !hit;
            stb_d   = 1'b1;
          end
`else
          data_d  = win;
          valid_d = !hit;
          stb_d   = 1'b1;
`endif
        end
      end
      default: begin
        state_d  = HUNT;
        bc_cnt_d = 4'd0;
        active_d = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q   <= HUNT;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      stb_q     <= 1'b0;
      active_q  <= 1'b0;
`ifdef SP_RX_LOS_EN
      los_cnt_q <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      stb_q     <= stb_d;
      active_q  <= active_d;
`ifdef SP_RX_LOS_EN
      los_cnt_q <= los_cnt_d;
`endif
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign byte_stb  = stb_q;
  assign active    = active_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Directed bench for serial_paralelo_rx.
// Build with SP_RX_LOS_EN to also exercise loss of sync.
module tb_serial_paralelo_rx;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_stb;
  logic       active;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int stb_cnt = 0;
  int last_stb = 0;
  int stb_per = 0;

  serial_paralelo_rx #(
    .LOS_BYTES (4)
  ) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .byte_stb  (byte_stb),
    .active    (active)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
    @(posedge clk_32f);
    #1;
    cyc++;
    if (byte_stb) begin
      stb_cnt++;
      stb_per  = cyc - last_stb;
      last_stb = cyc;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    reset   = 1'b1;
    data_in = 1'b0;
    @(posedge clk_32f);
    @(posedge clk_32f);
    #1;
    @(negedge clk_32f);
    reset   = 1'b0;
    stb_cnt = 0;
  endtask

  task automatic lock4();
    for (int i = 0; i < 4; i++) send_byte(8'hBC);
  endtask

  initial begin
    do_reset();
    chk("rst_data", data_out, 8'h00);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_stb", byte_stb, 1'b0);
    chk("rst_active", active, 1'b0);

    // clean lock
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    chk("lock3_active", active, 1'b0);
    chk("lock3_data", data_out, 8'h00);
    send_byte(8'hBC);
    chk("lock4_active", active, 1'b1);
    chk("lock4_nostb", stb_cnt, 0);
    send_byte(8'hA5);
    chk("a5_data", data_out, 8'hA5);
    chk("a5_valid", valid_out, 1'b1);
    chk("a5_stb", byte_stb, 1'b1);
    send_byte(8'h3C);
    chk("3c_data", data_out, 8'h3C);
    chk("3c_valid", valid_out, 1'b1);
    chk("stb_period", stb_per, 8);
    chk("stb_count", stb_cnt, 2);

    // idle in active
    send_byte(8'h11);
    chk("i11_data", data_out, 8'h11);
    chk("i11_valid", valid_out, 1'b1);
    send_byte(8'hBC);
    chk("ibc_data", data_out, 8'hBC);
    chk("ibc_valid", valid_out, 1'b0);
    chk("ibc_stb", byte_stb, 1'b1);
    send_byte(8'h22);
    chk("i22_data", data_out, 8'h22);
    chk("i22_valid", valid_out, 1'b1);

    // between slots, then reset mid-active
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    chk("mid_stb", byte_stb, 1'b0);
    chk("mid_data", data_out, 8'h22);
    chk("mid_valid", valid_out, 1'b1);
    @(negedge clk_32f);
    reset   = 1'b1;
    data_in = 1'b0;
    @(posedge clk_32f);
    #1;
    chk("mrst_data", data_out, 8'h00);
    chk("mrst_valid", valid_out, 1'b0);
    chk("mrst_active", active, 1'b0);
    @(negedge clk_32f);
    reset   = 1'b0;
    stb_cnt = 0;
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    chk("relock3", active, 1'b0);
    send_byte(8'hBC);
    chk("relock4", active, 1'b1);
    chk("relock_nostb", stb_cnt, 0);

    // misaligned start
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 0; i < 5; i++) send_byte(8'hBC);
    chk("mis_active", active, 1'b1);
    chk("mis_bc_valid", valid_out, 1'b0);
    send_byte(8'h5A);
    chk("mis_data", data_out, 8'h5A);
    chk("mis_valid", valid_out, 1'b1);
    chk("mis_stb", byte_stb, 1'b1);

    // broken lock
    do_reset();
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h00);
    chk("brk_active", active, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    chk("brk3_active", active, 1'b0);
    send_byte(8'hBC);
    chk("brk4_active", active, 1'b1);
    chk("brk_nostb", stb_cnt, 0);

`ifdef SP_RX_LOS_EN
    do_reset();
    lock4();
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h77);
      chk("los_valid", valid_out, 1'b1);
      chk("los_stb", byte_stb, 1'b1);
    end
    send_byte(8'h77);
    chk("los_active", active, 1'b0);
    chk("los_vld0", valid_out, 1'b0);
    chk("los_stb0", byte_stb, 1'b0);
    chk("los_cnt", stb_cnt, 3);
`else
    do_reset();
    lock4();
    for (int i = 0; i < 8; i++) send_byte(8'h77);
    chk("sticky_active", active, 1'b1);
    chk("sticky_valid", valid_out, 1'b1);
    chk("sticky_cnt", stb_cnt, 8);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
